xor_parity_rx: RTL and testbench

//  Serial parity-checking receiver: deframes start bit, DATA_W data bits (LSB first) and one parity bit.

---
 rtl/xor_parity_rx.sv | 192 +++++++++++++++++++
 tb/tb_xor_parity_rx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_rx.sv
// ============================================================================
// Module   : xor_parity_rx
// Purpose  : Serial parity-checking receiver. Deframes a start bit (1),
//            DATA_W data bits (LSB first) and one parity bit, checks parity
//            with an XOR reduction and presents the word on a valid/ready
//            output slot. Receive end of the XOR-parity serial link.
// Ports    : clk        - sole clock, rising edge
//            rst        - synchronous active-high reset
//            ser_in     - serial data bit
//            ser_valid  - qualifies ser_in; a bit is consumed only when 1
//            out_data   - received word (DATA_W bits)
//            out_perr   - parity (or framing) error for out_data
//            out_valid  - out_data/out_perr valid
//            out_ready  - downstream accepts when out_valid & out_ready
//            overrun    - 1-cycle pulse: completed frame dropped, slot full
//            busy       - receiver FSM not idle
// Params   : DATA_W (2..32), ODD_PARITY (0 = even, 1 = odd)
// Macro    : XOR_PARITY_RX_STOP_BIT_EN - adds a trailing stop bit (must be
//            0); a stop bit of 1 forces out_perr for that word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              ser_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              busy
);

    localparam int               CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             c_ODD      = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        c_ST_IDLE   = 2'd0,
        c_ST_DATA   = 2'd1,
`ifdef XOR_PARITY_RX_STOP_BIT_EN
        c_ST_PARITY = 2'd2,
        c_ST_STOP   = 2'd3
`else
        c_ST_PARITY = 2'd2
`endif
    } state_t;

    state_t              r_state_q,    w_state_d;
    logic [CNT_W-1:0]    r_cnt_q,      w_cnt_d;
    logic [DATA_W-1:0]   r_shreg_q,    w_shreg_d;
`ifdef XOR_PARITY_RX_STOP_BIT_EN
    logic                r_par_q,      w_par_d;
`endif
    logic [DATA_W-1:0]   r_out_data_q,  w_out_data_d;
    logic                r_out_perr_q,  w_out_perr_d;
    logic                r_out_valid_q, w_out_valid_d;
    logic                r_overrun_q,   w_overrun_d;
    logic                r_busy_q,      w_busy_d;

    logic                w_frame_done;
    logic                w_frame_perr;
    logic                w_slot_free;

    // ------------------------------------------------------------------
    // Deframer: next state, bit counter, shift register, completion flag.
    // Nothing moves unless ser_valid is high.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_shreg_d    = r_shreg_q;
`ifdef XOR_PARITY_RX_STOP_BIT_EN
        w_par_d      = r_par_q;
`endif
        w_frame_done = 1'b0;
        w_frame_perr = 1'b0;

        if (ser_valid) begin
            case (r_state_q)
                c_ST_IDLE: begin
                    // A 0 on the line is idle; a 1 is the start bit.
                    if (ser_in) begin
                        w_state_d = c_ST_DATA;
                        w_cnt_d   = '0;
                    end
                end
                c_ST_DATA: begin
                    w_shreg_d[r_cnt_q] = ser_in;
                    if (r_cnt_q == c_LAST_BIT) begin
                        w_state_d = c_ST_PARITY;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt_q + CNT_W'(1);
                    end
                end
                c_ST_PARITY: begin
`ifdef XOR_PARITY_RX_STOP_BIT_EN
                    w_par_d   = ser_in;
                    w_state_d = c_ST_STOP;
`else
                    // All data bits are already in the shift register here.
                    w_frame_done = 1'b1;
                    w_frame_perr = (^r_shreg_q) ^ ser_in ^ c_ODD;
                    w_state_d    = c_ST_IDLE;
`endif
                end
`ifdef XOR_PARITY_RX_STOP_BIT_EN
                c_ST_STOP: begin
                    // A stop bit of 1 is a framing error, reported as perr.
                    w_frame_done = 1'b1;
                    w_frame_perr = ((^r_shreg_q) ^ r_par_q ^ c_ODD) | ser_in;
                    w_state_d    = c_ST_IDLE;
                end
`endif
                default: begin
                    w_state_d = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output slot. A handshake in the completion cycle frees the slot, so
    // the new word replaces the accepted one without an overrun.
    // ------------------------------------------------------------------
    assign w_slot_free = !r_out_valid_q || out_ready;

    always_comb begin
        w_out_data_d  = r_out_data_q;
        w_out_perr_d  = r_out_perr_q;
        w_out_valid_d = r_out_valid_q;
        w_overrun_d   = 1'b0;

        if (w_frame_done) begin
            if (w_slot_free) begin
                w_out_data_d  = r_shreg_q;
                w_out_perr_d  = w_frame_perr;
                w_out_valid_d = 1'b1;
            end else begin
                w_overrun_d = 1'b1;
            end
        end else if (r_out_valid_q && out_ready) begin
            w_out_valid_d = 1'b0;
        end

        w_busy_d = (w_state_d != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_ST_IDLE;
            r_cnt_q       <= '0;
            r_shreg_q     <= '0;
`ifdef XOR_PARITY_RX_STOP_BIT_EN
            r_par_q       <= 1'b0;
`endif
            r_out_data_q  <= '0;
            r_out_perr_q  <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_overrun_q   <= 1'b0;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_shreg_q     <= w_shreg_d;
`ifdef XOR_PARITY_RX_STOP_BIT_EN
            r_par_q       <= w_par_d;
`endif
            r_out_data_q  <= w_out_data_d;
            r_out_perr_q  <= w_out_perr_d;
            r_out_valid_q <= w_out_valid_d;
            r_overrun_q   <= w_overrun_d;
            r_busy_q      <= w_busy_d;
        end
    end

    assign out_data  = r_out_data_q;
    assign out_perr  = r_out_perr_q;
    assign out_valid = r_out_valid_q;
    assign overrun   = r_overrun_q;
    assign busy      = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_parity_rx.sv
// ============================================================================
// Module   : tb_xor_parity_rx
// Purpose  : Self-checking bench for xor_parity_rx. Drives an even-parity and
//            an odd-parity instance with the same serial stream; a frame-level
//            model (bit list + ones count) predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_parity_rx;

    localparam int DW = 8;
`ifdef XOR_PARITY_RX_STOP_BIT_EN
    localparam int STOP_EN = 1;
`else
    localparam int STOP_EN = 0;
`endif
    // Bits following the start bit: data, parity and optional stop.
    localparam int FRAME_BITS = DW + 1 + STOP_EN;

    logic          clk = 1'b0;
    logic          rst;
    logic          ser_in;
    logic          ser_valid;
    logic          out_ready;
    logic [DW-1:0] out_data  [2];
    logic          out_perr  [2];
    logic          out_valid [2];
    logic          overrun   [2];
    logic          busy      [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en   = 1'b0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    xor_parity_rx #(.DATA_W(DW), .ODD_PARITY(0)) u_even (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .out_data(out_data[0]), .out_perr(out_perr[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .overrun(overrun[0]), .busy(busy[0])
    );

    xor_parity_rx #(.DATA_W(DW), .ODD_PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .out_data(out_data[1]), .out_perr(out_perr[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .overrun(overrun[1]), .busy(busy[1])
    );

    // ------------------------------------------------------------------
    // Reference model: collects the bits of a frame into a list, then
    // judges parity by counting ones. Index k of m_perr is the instance
    // with ODD_PARITY = k.
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] m_bits;
    int                    m_n;
    bit                    m_in;
    logic                  m_valid;
    logic                  m_ovr;
    logic [DW-1:0]         m_data;
    logic                  m_perr [2];
    logic                  m_busy;

    always @(posedge clk) begin : p_model
        bit            done;
        logic [DW-1:0] fd;
        logic          fp [2];
        int            ones;
        done = 1'b0;
        if (rst) begin
            m_in    = 1'b0;
            m_n     = 0;
            m_bits  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_data  = '0;
            m_perr  = '{1'b0, 1'b0};
        end else begin
            m_ovr = 1'b0;
            if (ser_valid) begin
                if (!m_in) begin
                    if (ser_in) begin
                        m_in = 1'b1;
                        m_n  = 0;
                    end
                end else begin
                    m_bits[m_n] = ser_in;
                    m_n++;
                    if (m_n == FRAME_BITS) begin
                        done = 1'b1;
                        m_in = 1'b0;
                    end
                end
            end
            if (done) begin
                fd   = m_bits[DW-1:0];
                ones = $countones(fd) + (m_bits[DW] ? 1 : 0);
                for (int k = 0; k < 2; k++) begin
                    fp[k] = ((ones % 2) != k);
                    if (STOP_EN != 0 && m_bits[FRAME_BITS-1]) fp[k] = 1'b1;
                end
                if (!m_valid || out_ready) begin
                    m_valid = 1'b1;
                    m_data  = fd;
                    m_perr  = fp;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        m_busy = m_in;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cyc_valid[%0d]", k), 32'(out_valid[k]), 32'(m_valid));
                chk($sformatf("cyc_overrun[%0d]", k), 32'(overrun[k]), 32'(m_ovr));
                chk($sformatf("cyc_busy[%0d]", k), 32'(busy[k]), 32'(m_busy));
                if (m_valid) begin
                    chk($sformatf("cyc_data[%0d]", k), 32'(out_data[k]), 32'(m_data));
                    chk($sformatf("cyc_perr[%0d]", k), 32'(out_perr[k]), 32'(m_perr[k]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Optional stall cycles (ser_in random, ser_valid low), then one bit.
    task automatic put_bit(input logic b, input int gap, input bit rdy);
        for (int i = 0; i < gap; i++) begin
            ser_valid = 1'b0;
            ser_in    = 1'($urandom_range(0, 1));
            tick();
        end
        ser_valid = 1'b1;
        ser_in    = b;
        if (rdy) out_ready = 1'b1;
        tick();
    endtask

    // Full frame; rdy_last raises out_ready in the completion cycle.
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stp,
                              input int gap, input bit rdy_last);
        logic [FRAME_BITS-1:0] fb;
        fb[DW-1:0] = d;
        fb[DW]     = p;
        if (STOP_EN != 0) fb[FRAME_BITS-1] = stp;
        put_bit(1'b1, gap, 1'b0);
        for (int i = 0; i < FRAME_BITS; i++)
            put_bit(fb[i], gap, rdy_last && (i == FRAME_BITS - 1));
        ser_valid = 1'b0;
        ser_in    = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        chk("drain_valid", 32'(out_valid[0]), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_data",  32'(out_data[0]),  32'd0);
        chk("rst_busy",  32'(busy[1]),      32'd0);
        chk("rst_ovr",   32'(overrun[1]),   32'd0);
        rst = 1'b0;
        tick();

        // 0xA5 has four ones: p=0 is good even parity, bad odd parity.
        send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);
        chk("t1_valid", 32'(out_valid[0]), 32'd1);
        chk("t1_data",  32'(out_data[0]),  32'hA5);
        chk("t1_perr_e", 32'(out_perr[0]), 32'd0);
        chk("t1_perr_o", 32'(out_perr[1]), 32'd1);
        chk("t1_model_data", 32'(m_data), 32'hA5);
        chk("t1_model_perr", 32'(m_perr[0]), 32'd0);
        tick();
        chk("t1_hold", 32'(out_data[0]), 32'hA5);
        drain();

        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
        chk("t2_data",   32'(out_data[0]), 32'hA5);
        chk("t2_perr_e", 32'(out_perr[0]), 32'd1);
        chk("t2_model_perr", 32'(m_perr[0]), 32'd1);
        drain();

        // Odd parity with 3 stall cycles before every bit.
        send_frame(8'h01, 1'b0, 1'b0, 3, 1'b0);
        chk("t3a_perr_o", 32'(out_perr[1]), 32'd0);
        chk("t3a_data",   32'(out_data[1]), 32'h01);
        drain();
        send_frame(8'h03, 1'b0, 1'b0, 3, 1'b0);
        chk("t3b_perr_o", 32'(out_perr[1]), 32'd1);
        chk("t3b_model_perr_o", 32'(m_perr[1]), 32'd1);
        drain();

        // Back-to-back frames into a blocked slot.
        send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 0, 1'b0);
        chk("t4_ovr",  32'(overrun[0]), 32'd1);
        chk("t4_data", 32'(out_data[0]), 32'h11);
        tick();
        chk("t4_ovr_pulse", 32'(overrun[0]), 32'd0);
        drain();

        // Handshake in the same cycle the next frame completes.
        send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 0, 1'b1);
        chk("t5_data",  32'(out_data[0]), 32'h33);
        chk("t5_valid", 32'(out_valid[0]), 32'd1);
        chk("t5_ovr",   32'(overrun[0]), 32'd0);
        tick();
        chk("t5_drain", 32'(out_valid[0]), 32'd0);
        out_ready = 1'b0;

        // Reset with a held word and a partial frame in flight.
        send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0);
        put_bit(1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'b1, 0, 1'b0);
        chk("t6_busy_pre", 32'(busy[0]), 32'd1);
        rst       = 1'b1;
        ser_valid = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(out_valid[0]), 32'd0);
        chk("t6_rst_busy",  32'(busy[0]),      32'd0);
        chk("t6_rst_data",  32'(out_data[0]),  32'd0);
        rst = 1'b0;
        tick();
        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
        chk("t6_data",   32'(out_data[0]), 32'h5A);
        chk("t6_perr_e", 32'(out_perr[0]), 32'(STOP_EN));
        chk("t6_ovr",    32'(overrun[0]),  32'd0);
        drain();

        // Randomized traffic with random ready, stalls and idle zeros.
        rand_rdy = 1'b1;
        for (int f = 0; f < 200; f++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            for (int z = 0; z < int'($urandom_range(0, 2)); z++)
                put_bit(1'b0, 0, 1'b0);
            send_frame(d, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                       1'b0);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        ser_valid = 1'b0;
        repeat (4) tick();
        chk("end_idle_busy", 32'(busy[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
